// File: rtl/ubtb_assoc_pkg.sv
// Shared types, default geometry and tag hashing for the set-associative micro-BTB.
package ubtb_assoc_pkg;

   localparam int unsigned UBTB_MXLEN   = 32;
   localparam int unsigned UBTB_SETS    = 16;
   localparam int unsigned UBTB_WAYS    = 2;
   localparam int unsigned UBTB_FETCH_W = 2;
   localparam int unsigned UBTB_TAG_W   = 8;

   localparam int unsigned UBTB_OFF_W  = (UBTB_FETCH_W > 1) ? $clog2(UBTB_FETCH_W) : 0;
   localparam int unsigned UBTB_SLOT_W = (UBTB_OFF_W > 0) ? UBTB_OFF_W : 1;
   localparam int unsigned UBTB_IDX_W  = $clog2(UBTB_SETS);

   // Entry layout for the default geometry
   typedef struct packed {
      logic                    valid;
      logic [UBTB_TAG_W-1:0]   tag;
      logic [UBTB_SLOT_W-1:0]  slot;
      logic [UBTB_MXLEN-1:0]   target;
   } ubtb_assoc_entry_t;

   // XOR-fold the PC bits above the index into tag_w-bit chunks (top chunk zero-extended)
   function automatic logic [63:0] ubtb_fold_tag(input logic [63:0] hi, input int unsigned tag_w);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < 64; i++) begin
         r[6'(32'(i) % tag_w)] = r[6'(32'(i) % tag_w)] ^ hi[i];
      end
      return r;
   endfunction

endpackage

// File: rtl/ubtb_assoc_plru.sv
// Tree pseudo-LRU state for one set: touch marks a way MRU, victim points at the LRU leaf.
module ubtb_plru #(
   parameter int unsigned WAYS = 2
)(
   input  logic                     i_clk,
   input  logic                     i_rstn,
   input  logic                     i_touch,
   input  logic [$clog2(WAYS)-1:0]  i_touch_way,
   output logic [$clog2(WAYS)-1:0]  o_victim
);

   localparam int unsigned WAY_W  = $clog2(WAYS);
   localparam int unsigned NODE_N = WAYS - 1;

   // Node n has children 2n+1 / 2n+2; a bit of 1 steers the victim walk to the upper half
   logic [NODE_N-1:0] tree;
   logic [NODE_N-1:0] tree_nxt;

   // Nodes on the touched way's path are turned to point away from it
   for (genvar l = 0; l < WAY_W; l++) begin : g_lvl
      for (genvar p = 0; p < (1 << l); p++) begin : g_node
         localparam int unsigned N = (1 << l) - 1 + p;
         logic on_path;
         if (l == 0) begin : g_root
            assign on_path = 1'b1;
         end else begin : g_inner
            assign on_path = (32'(i_touch_way[WAY_W-1 -: l]) == 32'(p));
         end
         assign tree_nxt[N] = (i_touch && on_path) ? ~i_touch_way[WAY_W-1-l] : tree[N];
      end
   end

   // Walk from the root following the node bits to find the victim leaf
   for (genvar l = 0; l < WAY_W; l++) begin : g_vic
      logic [l:0] path;
      if (l == 0) begin : g_root
         assign path = tree[0];
      end else begin : g_inner
         logic [(1<<l)-1:0] lvl;
         assign lvl  = tree[(1<<l)-1 +: (1<<l)];
         assign path = {g_vic[l-1].path, lvl[g_vic[l-1].path]};
      end
   end

   assign o_victim = g_vic[WAY_W-1].path;

   // Tree state register
   always_ff @(posedge i_clk) begin
      if (!i_rstn) tree <= '0;
      else         tree <= tree_nxt;
   end

endmodule

// File: rtl/ubtb_assoc.sv
// Set-associative micro-BTB: one-cycle lookup of the first predicted-taken slot in a fetch block.
module ubtb_assoc
   import ubtb_assoc_pkg::*;
#(
   parameter int unsigned MXLEN   = UBTB_MXLEN,
   parameter int unsigned SETS    = UBTB_SETS,
   parameter int unsigned WAYS    = UBTB_WAYS,
   parameter int unsigned FETCH_W = UBTB_FETCH_W,
   parameter int unsigned TAG_W   = UBTB_TAG_W
)(
   input  logic                                             i_clk,
   input  logic                                             i_rstn,
   input  logic                                             i_flush,
   input  logic                                             i_req_valid,
   input  logic [MXLEN-1:0]                                 i_req_pc,
   output logic                                             o_resp_valid,
   output logic                                             o_hit,
   output logic [((FETCH_W > 1) ? $clog2(FETCH_W) : 1)-1:0] o_hit_slot,
   output logic [MXLEN-1:0]                                 o_target,
   input  logic                                             i_upd_valid,
   input  logic [MXLEN-1:0]                                 i_upd_pc,
   input  logic                                             i_upd_taken,
   input  logic [MXLEN-1:0]                                 i_upd_target
);

   localparam int unsigned OFF_W  = (FETCH_W > 1) ? $clog2(FETCH_W) : 0;
   localparam int unsigned SLOT_W = (OFF_W > 0) ? OFF_W : 1;
   localparam int unsigned IDX_W  = $clog2(SETS);
   localparam int unsigned WAY_W  = $clog2(WAYS);

   typedef struct packed {
      logic               valid;
      logic [TAG_W-1:0]   tag;
      logic [SLOT_W-1:0]  slot;
      logic [MXLEN-1:0]   target;
   } entry_t;

   function automatic logic [SLOT_W-1:0] pc_slot(input logic [MXLEN-1:0] pc);
      return SLOT_W'((pc >> 2) & MXLEN'((64'd1 << OFF_W) - 64'd1));
   endfunction

   function automatic logic [IDX_W-1:0] pc_idx(input logic [MXLEN-1:0] pc);
      return IDX_W'(pc >> (2 + OFF_W));
   endfunction

   function automatic logic [TAG_W-1:0] pc_tag(input logic [MXLEN-1:0] pc);
      return TAG_W'(ubtb_fold_tag(64'(pc >> (2 + OFF_W + IDX_W)), TAG_W));
   endfunction

   entry_t            entries [SETS][WAYS];
   logic [WAY_W-1:0]  victim  [SETS];

   logic [IDX_W-1:0]  req_idx;
   logic [TAG_W-1:0]  req_tag;
   logic [SLOT_W-1:0] req_slot;
   logic              req_hit;
   logic [WAY_W-1:0]  req_way;
   logic [SLOT_W-1:0] req_best_slot;
   logic [MXLEN-1:0]  req_tgt;

   logic [IDX_W-1:0]  upd_idx;
   logic [TAG_W-1:0]  upd_tag;
   logic [SLOT_W-1:0] upd_slot;
   logic              upd_match;
   logic [WAY_W-1:0]  upd_mway;
   logic              upd_inv;
   logic [WAY_W-1:0]  upd_iway;
   logic [WAY_W-1:0]  upd_way;
   logic              upd_write;
   logic              upd_clear;

   assign req_idx  = pc_idx(i_req_pc);
   assign req_tag  = pc_tag(i_req_pc);
   assign req_slot = pc_slot(i_req_pc);
   assign upd_idx  = pc_idx(i_upd_pc);
   assign upd_tag  = pc_tag(i_upd_pc);
   assign upd_slot = pc_slot(i_upd_pc);

   // Lookup: matching way with the smallest slot at/after the request slot, lowest way on ties
   always_comb begin
      req_hit       = 1'b0;
      req_way       = '0;
      req_best_slot = '0;
      req_tgt       = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (entries[req_idx][WAY_W'(w)].valid &&
             entries[req_idx][WAY_W'(w)].tag == req_tag &&
             entries[req_idx][WAY_W'(w)].slot >= req_slot &&
             (!req_hit || entries[req_idx][WAY_W'(w)].slot < req_best_slot)) begin
            req_hit       = 1'b1;
            req_way       = WAY_W'(w);
            req_best_slot = entries[req_idx][WAY_W'(w)].slot;
            req_tgt       = entries[req_idx][WAY_W'(w)].target;
         end
      end
   end

   // Update way choice: exact {tag,slot} match, else first invalid way, else PLRU victim
   always_comb begin
      upd_match = 1'b0;
      upd_mway  = '0;
      upd_inv   = 1'b0;
      upd_iway  = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (!upd_match && entries[upd_idx][WAY_W'(w)].valid &&
             entries[upd_idx][WAY_W'(w)].tag == upd_tag &&
             entries[upd_idx][WAY_W'(w)].slot == upd_slot) begin
            upd_match = 1'b1;
            upd_mway  = WAY_W'(w);
         end
         if (!upd_inv && !entries[upd_idx][WAY_W'(w)].valid) begin
            upd_inv  = 1'b1;
            upd_iway = WAY_W'(w);
         end
      end
      upd_way   = upd_match ? upd_mway : (upd_inv ? upd_iway : victim[upd_idx]);
      upd_write = i_upd_valid && !i_flush && i_upd_taken;
      upd_clear = i_upd_valid && !i_flush && !i_upd_taken && upd_match;
   end

   // Per-set replacement state; an update touch overrides a read-hit touch in the same set
   for (genvar s = 0; s < SETS; s++) begin : g_set
      logic             touch;
      logic [WAY_W-1:0] touch_way;
      always_comb begin
         touch     = 1'b0;
         touch_way = '0;
         if (!i_flush) begin
            if (upd_write && upd_idx == IDX_W'(s)) begin
               touch     = 1'b1;
               touch_way = upd_way;
            end else if (i_req_valid && req_hit && req_idx == IDX_W'(s)) begin
               touch     = 1'b1;
               touch_way = req_way;
            end
         end
      end

      ubtb_plru #(.WAYS(WAYS)) u_plru (
         .i_clk       (i_clk),
         .i_rstn      (i_rstn),
         .i_touch     (touch),
         .i_touch_way (touch_way),
         .o_victim    (victim[s])
      );
   end

   // Entry table: reset clears everything, flush drops valid bits, then train/allocate/deallocate
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
               entries[IDX_W'(s)][WAY_W'(w)] <= '0;
      end else if (i_flush) begin
         for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
               entries[IDX_W'(s)][WAY_W'(w)].valid <= 1'b0;
      end else if (upd_write) begin
         entries[upd_idx][upd_way] <= '{valid: 1'b1, tag: upd_tag, slot: upd_slot,
                                        target: i_upd_target};
      end else if (upd_clear) begin
         entries[upd_idx][upd_way].valid <= 1'b0;
      end
   end

   // Registered response; flush squashes it
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         o_resp_valid <= 1'b0;
         o_hit        <= 1'b0;
         o_hit_slot   <= '0;
         o_target     <= '0;
      end else begin
         o_resp_valid <= i_req_valid && !i_flush;
         o_hit        <= i_req_valid && !i_flush && req_hit;
         o_hit_slot   <= (i_req_valid && !i_flush) ? req_best_slot : '0;
         o_target     <= (i_req_valid && !i_flush) ? req_tgt : '0;
      end
   end

endmodule

// File: tb/tb_ubtb_assoc.sv
// Scoreboard bench for ubtb_assoc: driver queues expected responses, monitor pops and compares.
module tb_ubtb_assoc;

   logic        clk = 1'b0;
   logic        i_rstn;
   logic        i_flush;
   logic        i_req_valid;
   logic [31:0] i_req_pc;
   logic        o_resp_valid;
   logic        o_hit;
   logic [0:0]  o_hit_slot;
   logic [31:0] o_target;
   logic        i_upd_valid;
   logic [31:0] i_upd_pc;
   logic        i_upd_taken;
   logic [31:0] i_upd_target;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [31:0] pc;
      logic        hit;
      logic [0:0]  slot;
      logic [31:0] tgt;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   ubtb_assoc #(
      .MXLEN(32), .SETS(16), .WAYS(2), .FETCH_W(2), .TAG_W(8)
   ) dut (
      .i_clk        (clk),
      .i_rstn       (i_rstn),
      .i_flush      (i_flush),
      .i_req_valid  (i_req_valid),
      .i_req_pc     (i_req_pc),
      .o_resp_valid (o_resp_valid),
      .o_hit        (o_hit),
      .o_hit_slot   (o_hit_slot),
      .o_target     (o_target),
      .i_upd_valid  (i_upd_valid),
      .i_upd_pc     (i_upd_pc),
      .i_upd_taken  (i_upd_taken),
      .i_upd_target (i_upd_target)
   );

   // Monitor: every presented response must match the oldest queued expectation
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (o_resp_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_resp: got hit=%0d slot=%0d tgt=%h, want no response",
                        o_hit, o_hit_slot, o_target);
            end else begin
               e = exp_q.pop_front();
               if (o_hit !== e.hit || o_hit_slot !== e.slot || o_target !== e.tgt) begin
                  errors++;
                  $display("FAIL resp pc=%h: got hit=%0d slot=%0d tgt=%h, want hit=%0d slot=%0d tgt=%h",
                           e.pc, o_hit, o_hit_slot, o_target, e.hit, e.slot, e.tgt);
               end
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Apply one cycle of inputs at a negedge; returns at the following negedge
   task automatic drive(input logic rv, input logic [31:0] rpc, input logic uv,
                        input logic [31:0] upc, input logic ut, input logic [31:0] utgt,
                        input logic fl, input logic rn);
      i_req_valid  = rv;
      i_req_pc     = rpc;
      i_upd_valid  = uv;
      i_upd_pc     = upc;
      i_upd_taken  = ut;
      i_upd_target = utgt;
      i_flush      = fl;
      i_rstn       = rn;
      @(negedge clk);
   endtask

   task automatic req(input logic [31:0] pc, input logic eh, input logic es, input logic [31:0] et);
      exp_q.push_back('{pc: pc, hit: eh, slot: es, tgt: et});
      drive(1'b1, pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
   endtask

   task automatic upd(input logic [31:0] pc, input logic t, input logic [31:0] tgt);
      drive(1'b0, 32'h0, 1'b1, pc, t, tgt, 1'b0, 1'b1);
   endtask

   task automatic idle();
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
   endtask

   task automatic flush();
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_resp_valid"}, 32'(o_resp_valid), 32'h0);
      chk({tag, "_hit"},        32'(o_hit),        32'h0);
      chk({tag, "_slot"},       32'(o_hit_slot),   32'h0);
      chk({tag, "_target"},     o_target,          32'h0);
   endtask

   initial begin
      i_rstn = 1'b0; i_flush = 1'b0; i_req_valid = 1'b0; i_req_pc = '0;
      i_upd_valid = 1'b0; i_upd_pc = '0; i_upd_taken = 1'b0; i_upd_target = '0;
      @(negedge clk);
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      chk_zero("reset");

      // 1: empty table misses; response drops when no new request
      req(32'h1000, 1'b0, 1'b0, 32'h0);
      idle();
      chk("resp_drop", 32'(o_resp_valid), 32'h0);

      // 2: single entry at slot 1
      upd(32'h1004, 1'b1, 32'h2000);
      req(32'h1000, 1'b1, 1'b1, 32'h2000);
      req(32'h1004, 1'b1, 1'b1, 32'h2000);
      req(32'h1008, 1'b0, 1'b0, 32'h0);

      // 3: two slots in the same block; retrain the slot-1 target
      upd(32'h1000, 1'b1, 32'hA000);
      upd(32'h1004, 1'b1, 32'hB000);
      req(32'h1000, 1'b1, 1'b0, 32'hA000);
      req(32'h1004, 1'b1, 1'b1, 32'hB000);
      flush();
      chk("flush_idle_resp", 32'(o_resp_valid), 32'h0);

      // 4: PLRU replacement in set 0
      upd(32'h1000, 1'b1, 32'h1111);
      upd(32'h1080, 1'b1, 32'h2222);
      req(32'h1000, 1'b1, 1'b0, 32'h1111);
      upd(32'h1100, 1'b1, 32'h3333);
      req(32'h1080, 1'b0, 1'b0, 32'h0);
      req(32'h1000, 1'b1, 1'b0, 32'h1111);
      req(32'h1100, 1'b1, 1'b0, 32'h3333);
      flush();

      // 5: deallocate, then read-before-write on a same-cycle request and update
      upd(32'h1004, 1'b1, 32'h2000);
      req(32'h1004, 1'b1, 1'b1, 32'h2000);
      upd(32'h1004, 1'b0, 32'h0);
      req(32'h1004, 1'b0, 1'b0, 32'h0);
      exp_q.push_back('{pc: 32'h1004, hit: 1'b0, slot: 1'b0, tgt: 32'h0});
      drive(1'b1, 32'h1004, 1'b1, 32'h1004, 1'b1, 32'h4000, 1'b0, 1'b1);
      req(32'h1004, 1'b1, 1'b1, 32'h4000);
      upd(32'h1000, 1'b0, 32'h0);
      req(32'h1004, 1'b1, 1'b1, 32'h4000);

      // 6: populate several sets, flush with a request and update in flight
      upd(32'h1000, 1'b1, 32'h5000);
      upd(32'h2008, 1'b1, 32'h6000);
      upd(32'h301C, 1'b1, 32'h7000);
      req(32'h2008, 1'b1, 1'b0, 32'h6000);
      req(32'h3018, 1'b1, 1'b1, 32'h7000);
      drive(1'b1, 32'h1000, 1'b1, 32'h1000, 1'b1, 32'h9999, 1'b1, 1'b1);
      chk("flush_req_resp", 32'(o_resp_valid), 32'h0);
      req(32'h1000, 1'b0, 1'b0, 32'h0);
      req(32'h2008, 1'b0, 1'b0, 32'h0);
      req(32'h3018, 1'b0, 1'b0, 32'h0);

      // Reset asserted mid-stream with a request and update pending
      upd(32'h1000, 1'b1, 32'h5000);
      req(32'h1000, 1'b1, 1'b0, 32'h5000);
      drive(1'b1, 32'h1000, 1'b1, 32'h2008, 1'b1, 32'h6000, 1'b0, 1'b0);
      chk_zero("midreset");
      req(32'h1000, 1'b0, 1'b0, 32'h0);
      req(32'h2008, 1'b0, 1'b0, 32'h0);

      idle();
      idle();
      chk("queue_empty", 32'(exp_q.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
